// File: rtl/mod13_count_monitor.sv
`timescale 1ns/1ps
// Synchronises and de-glitches a mod-13 ripple counter, checks its sequence,
// counts wraps in BCD and drives a two-digit 7-segment display.
module mod13_count_monitor #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    input  logic       clr_err,
    output logic [3:0] cnt_val,
    output logic       cnt_upd,
    output logic       wrap,
    output logic [7:0] wraps_bcd,
    output logic       illegal,
    output logic       skip,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);

    localparam logic [2:0] STABLE = 3'(STABLE_CYCLES);

    logic [3:0] s1_q, s2_q;
    logic [2:0] run_q, run_d;
    logic [3:0] val_q, val_d;
    logic       upd_q, upd_d;
    logic       wrap_q, wrap_d;
    logic [7:0] bcd_q, bcd_d;
    logic       ill_q, ill_d;
    logic       skip_q, skip_d;

    logic       accept;
    logic [3:0] nxt_exp;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Run length is updated on the same edge s2 loads, so it counts s2's age.
    always_comb begin
        run_d = run_q;
        if (s1_q != s2_q) begin
            run_d = 3'd1;
        end else if (run_q != STABLE) begin
            run_d = run_q + 3'd1;
        end
    end

    always_comb begin
        accept  = (run_q == STABLE) && (s2_q != val_q);
        nxt_exp = (val_q == 4'd12) ? 4'd0 : val_q + 4'd1;
        val_d   = accept ? s2_q : val_q;
        upd_d   = accept;
        wrap_d  = accept && (val_q == 4'd12) && (s2_q == 4'd0);
        ill_d   = (accept && (s2_q >= 4'd13)) || (ill_q && !clr_err);
        skip_d  = (accept && (s2_q < 4'd13) && (val_q < 4'd13) &&
                   (s2_q != nxt_exp)) || (skip_q && !clr_err);
    end

    always_comb begin
        bcd_d = bcd_q;
        if (wrap_d) begin
            if (bcd_q[3:0] == 4'd9) begin
                bcd_d[3:0] = 4'd0;
                bcd_d[7:4] = (bcd_q[7:4] == 4'd9) ? 4'd0 : bcd_q[7:4] + 4'd1;
            end else begin
                bcd_d[3:0] = bcd_q[3:0] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 4'd0;
            s2_q   <= 4'd0;
            run_q  <= 3'd0;
            val_q  <= 4'd0;
            upd_q  <= 1'b0;
            wrap_q <= 1'b0;
            bcd_q  <= 8'h00;
            ill_q  <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            s1_q   <= cnt_in;
            s2_q   <= s1_q;
            run_q  <= run_d;
            val_q  <= val_d;
            upd_q  <= upd_d;
            wrap_q <= wrap_d;
            bcd_q  <= bcd_d;
            ill_q  <= ill_d;
            skip_q <= skip_d;
        end
    end

    // Values 10-12 show a leading "1"; 13-15 show "E" with the tens blank.
    always_comb begin
        seg_tens = 7'h00;
        seg_ones = 7'h79;
        if (val_q < 4'd10) begin
            seg_ones = seg7(val_q);
        end else if (val_q < 4'd13) begin
            seg_tens = 7'h06;
            seg_ones = seg7(val_q - 4'd10);
        end
    end

    assign cnt_val   = val_q;
    assign cnt_upd   = upd_q;
    assign wrap      = wrap_q;
    assign wraps_bcd = bcd_q;
    assign illegal   = ill_q;
    assign skip      = skip_q;

endmodule

// File: tb/tb_mod13_count_monitor.sv
`timescale 1ns/1ps
// Directed bench for mod13_count_monitor: a reference model pushes expected
// acceptances to a queue, a negedge monitor pops them on every cnt_upd.
module tb_mod13_count_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt_in;
    logic       clr_err;
    logic [3:0] cnt_val;
    logic       cnt_upd;
    logic       wrap;
    logic [7:0] wraps_bcd;
    logic       illegal;
    logic       skip;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    mod13_count_monitor #(.STABLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .clr_err   (clr_err),
        .cnt_val   (cnt_val),
        .cnt_upd   (cnt_upd),
        .wrap      (wrap),
        .wraps_bcd (wraps_bcd),
        .illegal   (illegal),
        .skip      (skip),
        .seg_tens  (seg_tens),
        .seg_ones  (seg_ones)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] val;
        logic       wrap;
        logic [7:0] bcd;
        logic       ill;
        logic       skip;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int upd_seen = 0;

    logic [3:0] m_val;
    int         m_wraps;
    logic       m_ill;
    logic       m_skip;

    function automatic logic [7:0] to_bcd(input int c);
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [3:0] v);
        exp_t e;
        logic [3:0] p;
        p = m_val;
        e.wrap = 1'b0;
        if (v >= 4'd13) m_ill = 1'b1;
        else if (p < 4'd13) begin
            if (v != ((p == 4'd12) ? 4'd0 : p + 4'd1)) m_skip = 1'b1;
        end
        if (p == 4'd12 && v == 4'd0) begin
            e.wrap = 1'b1;
            m_wraps = (m_wraps + 1) % 100;
        end
        m_val  = v;
        e.val  = v;
        e.bcd  = to_bcd(m_wraps);
        e.ill  = m_ill;
        e.skip = m_skip;
        q.push_back(e);
    endtask

    // Holds of 1 cycle are glitches; holds of 4+ cycles must be accepted.
    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        if (n >= 4 && v != m_val) model_accept(v);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ill  = 1'b0;
        m_skip = 1'b0;
    endtask

    task automatic chk_reset(input string pfx);
        check({pfx, "_cnt_val"}, 8'(cnt_val), 8'h00);
        check({pfx, "_cnt_upd"}, 8'(cnt_upd), 8'h00);
        check({pfx, "_wrap"}, 8'(wrap), 8'h00);
        check({pfx, "_bcd"}, wraps_bcd, 8'h00);
        check({pfx, "_illegal"}, 8'(illegal), 8'h00);
        check({pfx, "_skip"}, 8'(skip), 8'h00);
        check({pfx, "_seg_tens"}, 8'(seg_tens), 8'h00);
        check({pfx, "_seg_ones"}, 8'(seg_ones), 8'h3F);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && cnt_upd) begin
            upd_seen++;
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_upd: observed cnt_val %h expected no update",
                       cnt_val);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sb_val", 8'(cnt_val), 8'(e.val));
                check("sb_wrap", 8'(wrap), 8'(e.wrap));
                check("sb_bcd", wraps_bcd, e.bcd);
                check("sb_illegal", 8'(illegal), 8'(e.ill));
                check("sb_skip", 8'(skip), 8'(e.skip));
            end
        end else if (!rst) begin
            check("wrap_without_upd", 8'(wrap), 8'h00);
        end
    end

    initial begin
        logic [7:0] prev;
        rst = 1'b1;
        cnt_in = 4'd0;
        clr_err = 1'b0;
        m_val = 4'd0;
        m_wraps = 0;
        m_ill = 1'b0;
        m_skip = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;

        // Count 0..12,0 at a comfortable rate
        hold(4'd0, 6);
        upd_seen = 0;
        for (int v = 1; v <= 12; v++) hold(4'(v), 6);
        hold(4'd0, 6);
        check("seq_upd_pulses", 8'(upd_seen), 8'd13);
        check("seq_bcd", wraps_bcd, 8'h01);
        check("seq_illegal", 8'(illegal), 8'h00);
        check("seq_skip", 8'(skip), 8'h00);

        // Ripple intermediates and the transient clear state 13
        for (int v = 1; v <= 7; v++) hold(4'(v), 6);
        hold(4'd6, 1);
        hold(4'd4, 1);
        hold(4'd0, 1);
        for (int v = 8; v <= 12; v++) hold(4'(v), 6);
        hold(4'd13, 1);
        hold(4'd0, 6);
        check("glitch_illegal", 8'(illegal), 8'h00);
        check("glitch_skip", 8'(skip), 8'h00);
        check("glitch_bcd", wraps_bcd, 8'h02);
        check("glitch_val", 8'(cnt_val), 8'h00);

        // Illegal value, resync, clear, clear colliding with a new illegal
        for (int v = 1; v <= 5; v++) hold(4'(v), 6);
        hold(4'd14, 6);
        check("ill14_flag", 8'(illegal), 8'h01);
        check("ill14_seg_ones", 8'(seg_ones), 8'h79);
        check("ill14_seg_tens", 8'(seg_tens), 8'h00);
        hold(4'd3, 6);
        check("resync_skip", 8'(skip), 8'h00);
        check("resync_illegal", 8'(illegal), 8'h01);
        clr();
        check("clr_illegal", 8'(illegal), 8'h00);
        cnt_in = 4'd15;
        model_accept(4'd15);
        repeat (3) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("set_wins_illegal", 8'(illegal), 8'h01);
        check("set_wins_val", 8'(cnt_val), 8'h0F);
        repeat (2) @(negedge clk);
        clr();
        hold(4'd4, 6);
        check("after15_skip", 8'(skip), 8'h00);
        hold(4'd7, 6);
        check("jump_skip", 8'(skip), 8'h01);
        check("jump_val", 8'(cnt_val), 8'h07);
        check("jump_seg_ones", 8'(seg_ones), 8'h07);
        check("jump_seg_tens", 8'(seg_tens), 8'h00);
        for (int v = 8; v <= 11; v++) hold(4'(v), 6);
        check("disp11_tens", 8'(seg_tens), 8'h06);
        check("disp11_ones", 8'(seg_ones), 8'h06);
        clr();
        check("clr_skip", 8'(skip), 8'h00);
        hold(4'd12, 6);
        check("disp12_ones", 8'(seg_ones), 8'h5B);
        hold(4'd0, 6);
        check("wrap3_bcd", wraps_bcd, 8'h03);

        // 100 full cycles at the maximum tracked rate
        for (int w = 0; w < 100; w++) begin
            prev = to_bcd(m_wraps);
            for (int v = 1; v <= 12; v++) hold(4'(v), 4);
            hold(4'd0, 4);
            if (prev == 8'h09) check("bcd_09_to_10", wraps_bcd, 8'h10);
            if (prev == 8'h99) check("bcd_99_to_00", wraps_bcd, 8'h00);
        end
        check("bcd_after_100", wraps_bcd, 8'h03);

        // Asynchronous reset in the middle of a count
        for (int v = 1; v <= 9; v++) hold(4'(v), 6);
        check("pre_rst_val", 8'(cnt_val), 8'h09);
        check("pre_rst_pending", 8'(q.size()), 8'h00);
        #2;
        rst = 1'b1;
        cnt_in = 4'd1;
        #1;
        chk_reset("async_rst");
        m_val = 4'd0;
        m_wraps = 0;
        m_ill = 1'b0;
        m_skip = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold(4'd1, 6);
        check("post_rst_val", 8'(cnt_val), 8'h01);
        check("post_rst_skip", 8'(skip), 8'h00);
        check("post_rst_bcd", wraps_bcd, 8'h00);

        check("sb_drained", 8'(q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
